// File: rtl/snake_input_ctrl.sv
// rtl/snake_input_ctrl.sv - debounced four-button direction input for a snake game
// Presses are filtered, prioritised and queued in pending; dir_o only moves on game_tick.
module snake_input_ctrl #(
    parameter int unsigned DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       game_tick,
    output logic [1:0] dir_o,
    output logic       dir_changed_o,
    output logic       press_o,
    output logic [3:0] btn_db_o
);

    localparam logic [15:0] LP_LAST = 16'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    logic [3:0]  w_raw;
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_db;
    logic [3:0]  r_db_q;
    logic [15:0] r_cnt [4];
    logic [1:0]  r_pending;
    logic [1:0]  r_dir;

    logic [3:0]  w_rise;
    logic        w_sel_vld;
    logic [1:0]  w_sel;
    logic [1:0]  w_ref;
    logic        w_accept;

    assign w_raw = {up, down, left, right};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A level is accepted only after DEBOUNCE_CNT consecutive mismatching cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db   <= '0;
            r_db_q <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_db_q <= r_db;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_LAST) begin
                    r_cnt[i] <= '0;
                    r_db[i]  <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign w_rise = r_db & ~r_db_q;

    always_comb begin
        w_sel_vld = |w_rise;
        w_sel     = DIR_RIGHT;
        if (w_rise[3]) begin
            w_sel = DIR_UP;
        end else if (w_rise[2]) begin
            w_sel = DIR_DOWN;
        end else if (w_rise[1]) begin
            w_sel = DIR_LEFT;
        end
    end

    // On a tick the press is judged against what is about to be committed.
    assign w_ref    = game_tick ? r_pending : r_dir;
    assign w_accept = w_sel_vld && (w_sel != (w_ref ^ 2'b10));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending     <= DIR_RIGHT;
            r_dir         <= DIR_RIGHT;
            dir_changed_o <= 1'b0;
            press_o       <= 1'b0;
        end else begin
            press_o       <= w_accept;
            dir_changed_o <= game_tick && (r_pending != r_dir);
            if (w_accept) begin
                r_pending <= w_sel;
            end
            if (game_tick) begin
                r_dir <= r_pending;
            end
        end
    end

    assign dir_o    = r_dir;
    assign btn_db_o = r_db;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb/tb_snake_input_ctrl.sv - directed self-checking bench for snake_input_ctrl
module tb_snake_input_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       game_tick = 1'b0;
    logic [1:0] dir_o;
    logic       dir_changed_o;
    logic       press_o;
    logic [3:0] btn_db_o;

    int checks = 0;
    int failures = 0;

    snake_input_ctrl #(.DEBOUNCE_CNT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .game_tick    (game_tick),
        .dir_o        (dir_o),
        .dir_changed_o(dir_changed_o),
        .press_o      (press_o),
        .btn_db_o     (btn_db_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int presses);
        presses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (press_o === 1'b1) presses++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {up, down, left, right} = 4'b0000;
        game_tick = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if ({dir_o, dir_changed_o, press_o, btn_db_o} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", {dir_o, dir_changed_o, press_o, btn_db_o}, 8'h00);
        end
        do_reset();
    endtask

    task automatic test_up_latency();
        int first;
        int presses;
        first = -1;
        presses = 0;
        do_reset();
        up = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            game_tick = (k == 30);
            step();
            if (press_o === 1'b1) begin
                presses++;
                if (first < 0) first = k;
            end
            if (k == 12) begin
                checks++;
                if (btn_db_o !== 4'b1000) begin
                    failures++;
                    $display("FAIL up_db_level got=%b want=1000", btn_db_o);
                end
            end
            if (k == 20) up = 1'b0;
        end
        game_tick = 1'b0;
        checks++;
        if (first != 7) begin
            failures++;
            $display("FAIL up_press_latency got=%0d want=7", first);
        end
        checks++;
        if (presses != 1) begin
            failures++;
            $display("FAIL up_press_count got=%0d want=1", presses);
        end
        checks++;
        if (dir_o !== 2'b11 || dir_changed_o !== 1'b1) begin
            failures++;
            $display("FAIL up_commit got=dir %b chg %b want=dir 11 chg 1", dir_o, dir_changed_o);
        end
        step();
        checks++;
        if (dir_changed_o !== 1'b0) begin
            failures++;
            $display("FAIL up_chg_single got=%b want=0", dir_changed_o);
        end
    endtask

    task automatic test_opposite();
        int presses;
        int p2;
        do_reset();
        left = 1'b1;
        run(10, presses);
        checks++;
        if (btn_db_o !== 4'b0010) begin
            failures++;
            $display("FAIL left_db_level got=%b want=0010", btn_db_o);
        end
        left = 1'b0;
        run(8, p2);
        presses += p2;
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
        checks++;
        if (presses != 0 || dir_o !== 2'b00 || dir_changed_o !== 1'b0) begin
            failures++;
            $display("FAIL opposite_discard got=press %0d dir %b chg %b want=press 0 dir 00 chg 0",
                     presses, dir_o, dir_changed_o);
        end
    endtask

    task automatic test_glitch();
        int presses;
        int bad_db;
        for (int len = 2; len <= 3; len++) begin
            do_reset();
            presses = 0;
            bad_db = 0;
            down = 1'b1;
            for (int k = 0; k < len; k++) step();
            down = 1'b0;
            for (int k = 0; k < 12; k++) begin
                step();
                if (press_o === 1'b1) presses++;
                if (btn_db_o !== 4'b0000) bad_db++;
            end
            checks++;
            if (presses != 0 || bad_db != 0) begin
                failures++;
                $display("FAIL glitch_len%0d got=press %0d db_changes %0d want=0 0", len, presses, bad_db);
            end
        end
    endtask

    task automatic test_simultaneous();
        int presses;
        do_reset();
        up = 1'b1;
        right = 1'b1;
        run(10, presses);
        checks++;
        if (presses != 1 || btn_db_o !== 4'b1001) begin
            failures++;
            $display("FAIL simul_press got=press %0d db %b want=press 1 db 1001", presses, btn_db_o);
        end
        up = 1'b0;
        right = 1'b0;
        run(8, presses);
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
        checks++;
        if (dir_o !== 2'b11 || dir_changed_o !== 1'b1) begin
            failures++;
            $display("FAIL simul_priority got=dir %b chg %b want=dir 11 chg 1", dir_o, dir_changed_o);
        end
    endtask

    task automatic test_coincident();
        int presses;
        do_reset();
        down = 1'b1;
        run(10, presses);
        down = 1'b0;
        run(8, presses);
        checks++;
        if (dir_o !== 2'b00) begin
            failures++;
            $display("FAIL no_tick_no_move got=%b want=00", dir_o);
        end
        left = 1'b1;
        run(6, presses);
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
        checks++;
        if (press_o !== 1'b1 || dir_o !== 2'b01 || dir_changed_o !== 1'b1) begin
            failures++;
            $display("FAIL coincident_tick got=press %b dir %b chg %b want=press 1 dir 01 chg 1",
                     press_o, dir_o, dir_changed_o);
        end
        left = 1'b0;
        run(10, presses);
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
        checks++;
        if (dir_o !== 2'b10 || dir_changed_o !== 1'b1) begin
            failures++;
            $display("FAIL coincident_next got=dir %b chg %b want=dir 10 chg 1", dir_o, dir_changed_o);
        end
    endtask

    task automatic test_back_to_back();
        int presses;
        up = 1'b1;
        run(10, presses);
        checks++;
        if (presses != 1 || dir_o !== 2'b10) begin
            failures++;
            $display("FAIL b2b_press got=press %0d dir %b want=press 1 dir 10", presses, dir_o);
        end
        up = 1'b0;
        run(8, presses);
        game_tick = 1'b1;
        step();
        checks++;
        if (dir_o !== 2'b11 || dir_changed_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got=dir %b chg %b want=dir 11 chg 1", dir_o, dir_changed_o);
        end
        step();
        game_tick = 1'b0;
        checks++;
        if (dir_o !== 2'b11 || dir_changed_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got=dir %b chg %b want=dir 11 chg 0", dir_o, dir_changed_o);
        end
    endtask

    task automatic test_reset_mid();
        int presses;
        int bad;
        do_reset();
        up = 1'b1;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        #1;
        checks++;
        if ({dir_o, dir_changed_o, press_o, btn_db_o} !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_async got=%b want=%b", {dir_o, dir_changed_o, press_o, btn_db_o}, 8'h00);
        end
        up = 1'b0;
        step();
        step();
        reset = 1'b0;
        presses = 0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (press_o === 1'b1) presses++;
            if ({dir_o, dir_changed_o, btn_db_o} !== 7'h00) bad++;
        end
        checks++;
        if (presses != 0 || bad != 0) begin
            failures++;
            $display("FAIL mid_reset_after got=press %0d nonreset %0d want=0 0", presses, bad);
        end
    endtask

    task automatic test_held_through_reset();
        int first;
        first = -1;
        reset = 1'b1;
        up = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (press_o === 1'b1 && first < 0) first = k;
        end
        checks++;
        if (first != 7) begin
            failures++;
            $display("FAIL held_reset_press got=%0d want=7", first);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_up_latency();
        test_opposite();
        test_glitch();
        test_simultaneous();
        test_coincident();
        test_back_to_back();
        test_reset_mid();
        test_held_through_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
